dds_sweep_ctrl: RTL and testbench

Frequency-sweep controller that drives the DDS frequency-word write interface (`data`/`we`/`ce`). On a start command it writes a programmed sequence of 32-bit frequency words, from a start word up to a stop word in fixed increments, holding each one for a programmed number of clock cycles. It supports single-shot and continuous (repeating) sweeps, plus abort. It sits between the control/register layer and the `dds` generator, and is the writer side of the DDS tuning interface.

---
 rtl/dds_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS frequency word from f_start up to f_stop in
// f_step increments, holding each word for a programmed dwell. Supports
// single-shot and continuous sweeps plus a level-sensitive abort.
// All outputs are registered. Each output is computed from the state being
// entered, so it lines up with that state's cycle.
module dds_sweep_ctrl #(
  parameter int FW_W    = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [FW_W-1:0]    f_start,
  input  logic [FW_W-1:0]    f_stop,
  input  logic [FW_W-1:0]    f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FW_W-1:0]    data,
  output logic               we,
  output logic               ce,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_ABORT} state_t;

  state_t             state_q, state_d;
  logic [FW_W-1:0]    cur_q, cur_d;
  logic [FW_W-1:0]    f_start_q, f_start_d;
  logic [FW_W-1:0]    f_stop_q, f_stop_d;
  logic [FW_W-1:0]    f_step_q, f_step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [FW_W-1:0]    data_q, data_d;
  logic               we_q, we_d;
  logic               ce_q, ce_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next word computed one bit wider so a wrap past all-ones ends the sweep.
  logic [FW_W:0] nxt;
  logic          cont;
  logic          expire;

  assign nxt    = {1'b0, cur_q} + {1'b0, f_step_q};
  assign cont   = !nxt[FW_W] && (nxt[FW_W-1:0] <= f_stop_q) && (f_step_q != '0);
  assign expire = (state_q == S_DWELL) && (cnt_q == '0) && !abort;

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      data_q    <= '0;
      we_q      <= 1'b0;
      ce_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      f_start_q <= f_start_d;
      f_stop_q  <= f_stop_d;
      f_step_q  <= f_step_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      we_q      <= we_d;
      ce_q      <= ce_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: abort outranks dwell expiry, which outranks start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_LOAD;
      S_LOAD:  state_d = abort ? S_ABORT : S_DWELL;
      S_DWELL: begin
        if (abort)                       state_d = S_ABORT;
        else if (cnt_q == '0)            state_d = (cont || mode_q) ? S_LOAD : S_IDLE;
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: config latch, current word and dwell counter.
  always_comb begin
    cur_d     = cur_q;
    f_start_d = f_start_q;
    f_stop_d  = f_stop_q;
    f_step_d  = f_step_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          f_start_d = f_start;
          f_stop_d  = f_stop;
          f_step_d  = f_step;
          dwell_d   = dwell;
          mode_d    = mode;
          cur_d     = f_start;
        end
      end
      // dwell of 0 behaves as 1, so the counter reload saturates at 0.
      S_LOAD: cnt_d = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
      S_DWELL: begin
        if (!abort) begin
          if (cnt_q != '0)  cnt_d = cnt_q - DWELL_W'(1);
          else if (cont)    cur_d = nxt[FW_W-1:0];
          else if (mode_q)  cur_d = f_start_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs: registered, derived from the state being entered.
  always_comb begin
    we_d   = (state_d == S_LOAD) || (state_d == S_ABORT);
    busy_d = (state_d != S_IDLE);
    data_d = data_q;
    if (state_d == S_LOAD)       data_d = cur_d;
    else if (state_d == S_ABORT) data_d = '0;
    // ce holds the final tone after a single sweep; only an abort drops it.
    ce_d = ce_q;
    if (state_d == S_LOAD)       ce_d = 1'b1;
    else if (state_q == S_ABORT) ce_d = 1'b0;
    done_d = expire && !cont && !mode_q;
  end

  assign data = data_q;
  assign we   = we_q;
  assign ce   = ce_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed table of single sweeps plus hand-written
// sequences for continuous mode, abort, reset and back-to-back start.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, mode;
  logic [31:0] f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [31:0] data;
  logic        we, ce, busy, done;

  int n_vec = 0;
  int n_err = 0;

  dds_sweep_ctrl #(.FW_W(32), .DWELL_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .data(data), .we(we), .ce(ce), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] fs, fe, st;
    logic [15:0] dw;
    int          nw;
    logic [31:0] ew [4];
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [31:0] fs, fe, st,
                              input logic [15:0] dw, input int nw,
                              input logic [31:0] e0, e1, e2, e3);
    vec_t v;
    v.m = m; v.fs = fs; v.fe = fe; v.st = st; v.dw = dw; v.nw = nw;
    v.ew[0] = e0; v.ew[1] = e1; v.ew[2] = e2; v.ew[3] = e3;
    return v;
  endfunction

  task automatic set_cfg(input logic m, input logic [31:0] fs, fe, st, input logic [15:0] dw);
    mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
  endtask

  // Called just after a negedge; cycle c is the c-th negedge after start.
  task automatic run_vec(input vec_t v);
    int t[$];
    logic [31:0] w[$];
    int tdone = -1;
    int d = (v.dw == 16'd0) ? 1 : int'(v.dw);
    logic [31:0] last = v.ew[v.nw-1];
    set_cfg(v.m, v.fs, v.fe, v.st, v.dw);
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (we) begin t.push_back(c); w.push_back(data); end
      if (done) begin
        tdone = c;
        chk("busy_at_done", busy, 0);
        chk("ce_at_done", ce, 1);
        chk("data_hold_at_done", data, last);
        break;
      end
    end
    chk("done_seen", tdone > 0, 1);
    chk("n_words", t.size(), v.nw);
    for (int i = 0; i < v.nw && i < t.size(); i++) begin
      chk("word", w[i], v.ew[i]);
      chk("we_time", t[i], 1 + i*(d+1));
    end
    chk("done_time", tdone, v.nw*(d+1) + 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ce_after", ce, 1);
    chk("data_after", data, last);
    chk("we_after", we, 0);
  endtask

  vec_t vt [7];

  initial begin
    vt[0] = mk(0, 32'd100, 32'd400, 32'd100, 16'd3, 4, 100, 200, 300, 400);
    vt[1] = mk(0, 32'd100, 32'd350, 32'd100, 16'd3, 3, 100, 200, 300, 0);
    vt[2] = mk(0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd2, 1, 32'hFFFF_FF00, 0, 0, 0);
    vt[3] = mk(0, 32'd10, 32'd16, 32'd2, 16'd0, 4, 10, 12, 14, 16);
    vt[4] = mk(0, 32'd7, 32'd1000, 32'd0, 16'd1, 1, 7, 0, 0, 0);
    vt[5] = mk(0, 32'd500, 32'd100, 32'd100, 16'd2, 1, 500, 0, 0, 0);
    vt[6] = mk(0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 16'd1, 2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0);

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    #12;
    chk("rst_data", data, 0); chk("rst_we", we, 0); chk("rst_ce", ce, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      run_vec(vt[i]);
      @(negedge clk);
    end

    // abort in IDLE is inert; start with abort high is not accepted
    abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_we", we, 0); chk("idle_abort_ce", ce, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_with_abort_we", we, 0); chk("start_with_abort_busy", busy, 0);
    @(negedge clk);

    // continuous mode, then abort exactly at dwell expiry
    begin
      int nwe = 0, ndn = 0;
      logic [31:0] cseq [3] = '{32'd100, 32'd200, 32'd300};
      set_cfg(1, 32'd100, 32'd300, 32'd100, 16'd2);
      start = 1'b1;
      for (int c = 1; c <= 24; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) ndn++;
        if (we) begin
          chk("cont_time", c, 1 + nwe*3);
          chk("cont_word", data, cseq[nwe % 3]);
          nwe++;
        end
      end
      chk("cont_nwe", nwe, 8);
      chk("cont_no_done", ndn, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("cont_abort_we", we, 1); chk("cont_abort_data", data, 0);
      chk("cont_abort_busy", busy, 1);
      @(negedge clk);
      chk("cont_post_busy", busy, 0); chk("cont_post_ce", ce, 0);
      chk("cont_post_done", done, 0);
      @(negedge clk);
    end

    // single sweep: start while busy ignored, abort in the second dwell
    set_cfg(0, 32'd100, 32'd400, 32'd100, 16'd3);
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      case (c)
        1: begin chk("ab_w1", we, 1); chk("ab_d1", data, 100); chk("ab_busy1", busy, 1); end
        3: begin start = 1'b1; f_start = 32'd999; end
        4: chk("ab_start_ignored", we, 0);
        5: begin chk("ab_w2", we, 1); chk("ab_d2", data, 200); end
        6: abort = 1'b1;
        7: begin abort = 1'b0; chk("ab_we", we, 1); chk("ab_data", data, 0);
                  chk("ab_busy", busy, 1); chk("ab_ce", ce, 1); end
        8: begin chk("ab_post_busy", busy, 0); chk("ab_post_ce", ce, 0);
                  chk("ab_post_we", we, 0); chk("ab_no_done", done, 0); end
        default: ;
      endcase
    end

    // async reset mid-dwell, then restart
    set_cfg(0, 32'd100, 32'd400, 32'd100, 16'd3);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_data", data, 0); chk("async_we", we, 0); chk("async_ce", ce, 0);
    chk("async_busy", busy, 0); chk("async_done", done, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    set_cfg(0, 32'd777, 32'd800, 32'd50, 16'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("post_rst_we", we, 1); chk("post_rst_data", data, 777);
    chk("post_rst_busy", busy, 1);

    // start accepted in the done cycle (5->6, dwell 0: we at 1,3; done at 5)
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    chk("idle_before_b2b", busy, 0);
    set_cfg(0, 32'd5, 32'd6, 32'd1, 16'd0);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin chk("b2b_w2", we, 1); chk("b2b_d2", data, 6); end
      if (c == 5) begin
        chk("b2b_done", done, 1);
        set_cfg(0, 32'd42, 32'd42, 32'd0, 16'd0);
        start = 1'b1;
      end
      if (c == 6) begin chk("b2b_we", we, 1); chk("b2b_data", data, 42); chk("b2b_busy", busy, 1); end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
